// File: rtl/spell_stack.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : spell_stack
// Description : Parametrised data stack with a combined pop/push op per
//               cycle, overflow/underflow flags and a host debug port.
//               Optional peak-occupancy tracking enabled by the
//               SPELL_STACK_HWM_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module spell_stack #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 32,
    parameter int WRAP   = 1,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_op_valid,
    output logic             o_op_ready,
    input  logic [1:0]       i_pop,
    input  logic [1:0]       i_push,
    input  logic [WIDTH-1:0] i_set_top,
    input  logic [WIDTH-1:0] i_set_below,
    output logic [WIDTH-1:0] o_top,
    output logic [WIDTH-1:0] o_below,
    output logic [PW:0]      o_sp,
    input  logic             i_dbg_write,
    input  logic [1:0]       i_dbg_addr,
    input  logic [WIDTH-1:0] i_dbg_data,
    output logic             o_overflow,
    output logic             o_underflow,
    output logic             o_irq,
    output logic [PW:0]      o_max_depth
);

    localparam logic signed [PW+1:0] c_depth_s = (PW+2)'(DEPTH);
    localparam logic [PW:0]          c_depth_u = (PW+1)'(DEPTH);
    localparam logic [1:0]           c_addr_sp    = 2'd0;
    localparam logic [1:0]           c_addr_poke  = 2'd1;
    localparam logic [1:0]           c_addr_push  = 2'd2;
    localparam logic [1:0]           c_addr_clear = 2'd3;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW:0]      r_sp;
    logic             r_ovf;
    logic             r_unf;

    logic             w_op_fire;
    logic             w_dbg_push;
    logic             w_exec;
    logic [1:0]       w_pop_eff;
    logic [1:0]       w_push_eff;
    logic [WIDTH-1:0] w_top_val;
    logic signed [PW+1:0] w_sp_calc;
    logic             w_under;
    logic             w_over;
    logic             w_commit;
    logic [PW:0]      w_sp_new;
    logic [PW-1:0]    w_idx_new_top;
    logic [PW-1:0]    w_idx_new_below;
    logic [PW-1:0]    w_idx_rd_top;
    logic [PW-1:0]    w_idx_rd_below;
    logic [PW:0]      w_dbg_trunc;
    logic [PW:0]      w_dbg_sp;
    logic [PW:0]      w_sp_next;
    logic             w_ovf_next;
    logic             w_unf_next;
    logic             w_clr;
    logic             w_we_top;
    logic [PW-1:0]    w_wr_top_idx;
    logic [WIDTH-1:0] w_wr_top_data;
    logic             w_we_below;

    assign o_op_ready = ~i_dbg_write;

    // A debug push reuses the op datapath as push=1, pop=0.
    assign w_op_fire  = i_op_valid & ~i_dbg_write;
    assign w_dbg_push = i_dbg_write & (i_dbg_addr == c_addr_push);
    assign w_exec     = w_op_fire | w_dbg_push;
    assign w_pop_eff  = w_dbg_push ? 2'd0 : ((i_pop  == 2'd3) ? 2'd2 : i_pop);
    assign w_push_eff = w_dbg_push ? 2'd1 : ((i_push == 2'd3) ? 2'd2 : i_push);
    assign w_top_val  = w_dbg_push ? i_dbg_data : i_set_top;

    assign w_sp_calc = $signed({1'b0, r_sp})
                     - $signed({{PW{1'b0}}, w_pop_eff})
                     + $signed({{PW{1'b0}}, w_push_eff});
    assign w_under   = ({{(PW-1){1'b0}}, w_pop_eff} > r_sp);
    assign w_over    = (w_sp_calc > c_depth_s);
    assign w_commit  = w_exec & ((WRAP != 0) | ~(w_under | w_over));
    assign w_sp_new  = (WRAP != 0) ? {1'b0, w_sp_calc[PW-1:0]} : w_sp_calc[PW:0];

    assign w_idx_new_top   = w_sp_new[PW-1:0] - PW'(1);
    assign w_idx_new_below = w_sp_new[PW-1:0] - PW'(2);
    assign w_idx_rd_top    = r_sp[PW-1:0] - PW'(1);
    assign w_idx_rd_below  = r_sp[PW-1:0] - PW'(2);

    generate
        if (WIDTH >= PW + 1) begin : g_dbg_trunc
            assign w_dbg_trunc = i_dbg_data[PW:0];
        end else begin : g_dbg_extend
            assign w_dbg_trunc = {{(PW+1-WIDTH){1'b0}}, i_dbg_data};
        end
    endgenerate

    // Host SP writes wrap to PW bits, or saturate at DEPTH when not wrapping.
    assign w_dbg_sp = (WRAP != 0) ? {1'b0, w_dbg_trunc[PW-1:0]}
                    : ((w_dbg_trunc > c_depth_u) ? c_depth_u : w_dbg_trunc);

    always_comb begin
        w_sp_next  = r_sp;
        w_ovf_next = r_ovf;
        w_unf_next = r_unf;
        w_clr      = 1'b0;
        if (i_dbg_write) begin
            case (i_dbg_addr)
                c_addr_sp: w_sp_next = w_dbg_sp;
                c_addr_clear: begin
                    w_ovf_next = 1'b0;
                    w_unf_next = 1'b0;
                    w_clr      = 1'b1;
                end
                default: ;
            endcase
        end
        if (w_exec) begin
            if (w_under) w_unf_next = 1'b1;
            if (w_over)  w_ovf_next = 1'b1;
            if (w_commit) w_sp_next = w_sp_new;
        end
    end

    // Host poke and op/debug-push writes are mutually exclusive in a cycle.
    assign w_we_top      = (w_commit & (w_push_eff != 2'd0))
                         | (i_dbg_write & (i_dbg_addr == c_addr_poke));
    assign w_wr_top_idx  = w_commit ? w_idx_new_top : w_idx_rd_top;
    assign w_wr_top_data = w_commit ? w_top_val : i_dbg_data;
    assign w_we_below    = w_commit & (w_push_eff == 2'd2);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sp  <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_sp  <= w_sp_next;
            r_ovf <= w_ovf_next;
            r_unf <= w_unf_next;
            if (w_we_top) begin
                r_mem[w_wr_top_idx] <= w_wr_top_data;
            end
            if (w_we_below) begin
                r_mem[w_idx_new_below] <= i_set_below;
            end
        end
    end

    assign o_top       = r_mem[w_idx_rd_top];
    assign o_below     = r_mem[w_idx_rd_below];
    assign o_sp        = r_sp;
    assign o_overflow  = r_ovf;
    assign o_underflow = r_unf;
    assign o_irq       = r_ovf | r_unf;

`ifdef SPELL_STACK_HWM_EN
    logic [PW:0] r_max_depth;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_max_depth <= '0;
        end else if (w_clr) begin
            r_max_depth <= '0;
        end else if (w_sp_next > r_max_depth) begin
            r_max_depth <= w_sp_next;
        end
    end

    assign o_max_depth = r_max_depth;
`else
    logic w_unused_clr;
    assign w_unused_clr = w_clr;
    assign o_max_depth  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spell_stack.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_spell_stack
// Description : Randomised scoreboard bench running a WRAP=0 and a WRAP=1
//               spell_stack side by side against a queue/array stack model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spell_stack;

    localparam int WIDTH = 8;
    localparam int DEPTH = 32;
    localparam int PW    = 5;

    typedef struct packed {
        logic [PW:0]      sp;
        logic [WIDTH-1:0] top;
        logic [WIDTH-1:0] below;
        logic             ovf;
        logic             unf;
        logic             irq;
        logic [PW:0]      maxd;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             op_valid = 1'b0;
    logic [1:0]       pop = '0;
    logic [1:0]       push = '0;
    logic [WIDTH-1:0] set_top = '0;
    logic [WIDTH-1:0] set_below = '0;
    logic             dbg_write = 1'b0;
    logic [1:0]       dbg_addr = '0;
    logic [WIDTH-1:0] dbg_data = '0;

    logic [1:0]            ready_o;
    logic [1:0][WIDTH-1:0] top_o;
    logic [1:0][WIDTH-1:0] below_o;
    logic [1:0][PW:0]      sp_o;
    logic [1:0]            ovf_o;
    logic [1:0]            unf_o;
    logic [1:0]            irq_o;
    logic [1:0][PW:0]      maxd_o;

    always #5 clock = ~clock;

    spell_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .WRAP(0)) u_nowrap (
        .clock(clock), .reset(reset), .i_op_valid(op_valid), .o_op_ready(ready_o[0]),
        .i_pop(pop), .i_push(push), .i_set_top(set_top), .i_set_below(set_below),
        .o_top(top_o[0]), .o_below(below_o[0]), .o_sp(sp_o[0]),
        .i_dbg_write(dbg_write), .i_dbg_addr(dbg_addr), .i_dbg_data(dbg_data),
        .o_overflow(ovf_o[0]), .o_underflow(unf_o[0]), .o_irq(irq_o[0]),
        .o_max_depth(maxd_o[0])
    );

    spell_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .WRAP(1)) u_wrap (
        .clock(clock), .reset(reset), .i_op_valid(op_valid), .o_op_ready(ready_o[1]),
        .i_pop(pop), .i_push(push), .i_set_top(set_top), .i_set_below(set_below),
        .o_top(top_o[1]), .o_below(below_o[1]), .o_sp(sp_o[1]),
        .i_dbg_write(dbg_write), .i_dbg_addr(dbg_addr), .i_dbg_data(dbg_data),
        .o_overflow(ovf_o[1]), .o_underflow(unf_o[1]), .o_irq(irq_o[1]),
        .o_max_depth(maxd_o[1])
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string name, input int w, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s (wrap=%0d) at %0t: got %0h, expected %0h", name, w, $time, act, exp);
        end
    endtask

    // Reference model: index 0 is the non-wrapping stack, index 1 the wrapping one.
    int               m_sp  [2];
    logic [WIDTH-1:0] m_mem [2][DEPTH];
    bit               m_ovf [2];
    bit               m_unf [2];
    int               m_max [2];

    function automatic int md(input int v);
        return ((v % DEPTH) + DEPTH) % DEPTH;
    endfunction

    task automatic model_reset();
        for (int w = 0; w < 2; w++) begin
            m_sp[w] = 0; m_ovf[w] = 0; m_unf[w] = 0; m_max[w] = 0;
            for (int i = 0; i < DEPTH; i++) m_mem[w][i] = '0;
        end
    endtask

    task automatic model_op(input int w, input int p, input int q,
                            input logic [WIDTH-1:0] t, input logic [WIDTH-1:0] b);
        int n;
        bit u;
        bit o;
        n = m_sp[w] - p + q;
        u = (p > m_sp[w]);
        o = (n > DEPTH);
        if (u) m_unf[w] = 1;
        if (o) m_ovf[w] = 1;
        if (w == 1 || !(u || o)) begin
            m_sp[w] = (w == 1) ? md(n) : n;
            if (q >= 1) m_mem[w][md(m_sp[w] - 1)] = t;
            if (q == 2) m_mem[w][md(m_sp[w] - 2)] = b;
        end
    endtask

    task automatic model_step(input int w, input bit v, input int p, input int q,
                              input logic [WIDTH-1:0] t, input logic [WIDTH-1:0] b,
                              input bit d, input int a, input logic [WIDTH-1:0] data);
        int nv;
        bit clr;
        clr = 0;
        if (d) begin
            case (a)
                0: begin
                    if (w == 1) nv = int'(data) % DEPTH;
                    else begin
                        nv = int'(data) % (2 * DEPTH);
                        if (nv > DEPTH) nv = DEPTH;
                    end
                    m_sp[w] = nv;
                end
                1: m_mem[w][md(m_sp[w] - 1)] = data;
                2: model_op(w, 0, 1, data, '0);
                default: begin
                    m_ovf[w] = 0; m_unf[w] = 0; clr = 1;
                end
            endcase
        end else if (v) begin
            model_op(w, (p > 2) ? 2 : p, (q > 2) ? 2 : q, t, b);
        end
`ifdef SPELL_STACK_HWM_EN
        if (clr) m_max[w] = 0;
        else if (m_sp[w] > m_max[w]) m_max[w] = m_sp[w];
`else
        m_max[w] = 0;
`endif
    endtask

    function automatic exp_t model_exp(input int w);
        exp_t e;
        e.sp    = (PW+1)'(m_sp[w]);
        e.top   = m_mem[w][md(m_sp[w] - 1)];
        e.below = m_mem[w][md(m_sp[w] - 2)];
        e.ovf   = m_ovf[w];
        e.unf   = m_unf[w];
        e.irq   = m_ovf[w] | m_unf[w];
        e.maxd  = (PW+1)'(m_max[w]);
        return e;
    endfunction

    exp_t q0[$];
    exp_t q1[$];
    exp_t pend[2];
    bit   have_pend = 0;

    task automatic compare_dut(input int w, input exp_t e);
        chk("sp",        w, 32'(sp_o[w]),    32'(e.sp));
        chk("top",       w, 32'(top_o[w]),   32'(e.top));
        chk("below",     w, 32'(below_o[w]), 32'(e.below));
        chk("overflow",  w, 32'(ovf_o[w]),   32'(e.ovf));
        chk("underflow", w, 32'(unf_o[w]),   32'(e.unf));
        chk("irq",       w, 32'(irq_o[w]),   32'(e.irq));
        chk("max_depth", w, 32'(maxd_o[w]),  32'(e.maxd));
    endtask

    // Monitor: each expectation becomes due at the falling edge after its commit.
    initial begin
        forever begin
            @(negedge clock);
            if (q0.size() > 0) compare_dut(0, q0.pop_front());
            if (q1.size() > 0) compare_dut(1, q1.pop_front());
        end
    end

    task automatic step(input bit v, input int p, input int q,
                        input logic [WIDTH-1:0] t, input logic [WIDTH-1:0] b,
                        input bit d, input int a, input logic [WIDTH-1:0] data);
        @(posedge clock);
        #1;
        if (have_pend) begin
            q0.push_back(pend[0]);
            q1.push_back(pend[1]);
        end
        op_valid  = v;
        pop       = p[1:0];
        push      = q[1:0];
        set_top   = t;
        set_below = b;
        dbg_write = d;
        dbg_addr  = a[1:0];
        dbg_data  = data;
        for (int w = 0; w < 2; w++) begin
            model_step(w, v, p, q, t, b, d, a, data);
            pend[w] = model_exp(w);
        end
        have_pend = 1;
        #1;
        chk("op_ready", 0, 32'(ready_o[0]), 32'(!d));
        chk("op_ready", 1, 32'(ready_o[1]), 32'(!d));
    endtask

    task automatic idle();
        step(0, 0, 0, '0, '0, 0, 0, '0);
    endtask

    task automatic op(input int p, input int q, input logic [WIDTH-1:0] t, input logic [WIDTH-1:0] b);
        step(1, p, q, t, b, 0, 0, '0);
    endtask

    task automatic dbg(input int a, input logic [WIDTH-1:0] data);
        step(0, 0, 0, '0, '0, 1, a, data);
    endtask

    task automatic chk_zero_state(input string tag);
        for (int w = 0; w < 2; w++) begin
            chk({tag, "_sp"},    w, 32'(sp_o[w]),    0);
            chk({tag, "_top"},   w, 32'(top_o[w]),   0);
            chk({tag, "_below"}, w, 32'(below_o[w]), 0);
            chk({tag, "_ovf"},   w, 32'(ovf_o[w]),   0);
            chk({tag, "_unf"},   w, 32'(unf_o[w]),   0);
            chk({tag, "_irq"},   w, 32'(irq_o[w]),   0);
            chk({tag, "_maxd"},  w, 32'(maxd_o[w]),  0);
            chk({tag, "_ready"}, w, 32'(ready_o[w]), 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        #12;
        chk_zero_state("reset");
        @(negedge clock);
        reset = 1'b0;

        // Three pushes, then an ALU-style pop-2/push-1.
        op(0, 1, 8'd11, '0);
        op(0, 1, 8'd22, '0);
        op(0, 1, 8'd33, '0);
        idle();
        for (int w = 0; w < 2; w++) begin
            chk("push3_sp",    w, 32'(sp_o[w]),    3);
            chk("push3_top",   w, 32'(top_o[w]),   33);
            chk("push3_below", w, 32'(below_o[w]), 22);
        end
        op(2, 1, 8'd55, '0);
        idle();
        for (int w = 0; w < 2; w++) begin
            chk("alu_sp",    w, 32'(sp_o[w]),    2);
            chk("alu_top",   w, 32'(top_o[w]),   55);
            chk("alu_below", w, 32'(below_o[w]), 11);
        end

        // Asynchronous reset between clock edges with sp=5.
        op(0, 2, 8'd1, 8'd2);
        op(0, 1, 8'd3, '0);
        idle();
        chk("pre_reset_sp", 0, 32'(sp_o[0]), 5);
        #4;
        reset = 1'b1;
        #1;
        chk_zero_state("async_reset");
        have_pend = 0;
        model_reset();
        @(posedge clock);
        #3;
        reset = 1'b0;

        // Overflow at sp=31 with push=2.
        dbg(0, 8'd31);
        op(0, 2, 8'h77, 8'h66);
        idle();
        chk("ovf_flag", 0, 32'(ovf_o[0]), 1);
        chk("ovf_irq",  0, 32'(irq_o[0]), 1);
        chk("ovf_sp",   0, 32'(sp_o[0]),  31);
        chk("ovf_flag", 1, 32'(ovf_o[1]), 1);
        chk("ovf_sp",   1, 32'(sp_o[1]),  1);
        chk("ovf_top",  1, 32'(top_o[1]), 32'h77);
        chk("ovf_below",1, 32'(below_o[1]), 32'h66);

        // Underflow at sp=1 with pop=2, then clear.
        dbg(3, '0);
        dbg(0, 8'd1);
        op(2, 0, '0, '0);
        idle();
        chk("unf_flag", 0, 32'(unf_o[0]), 1);
        chk("unf_sp",   0, 32'(sp_o[0]),  1);
        chk("unf_flag", 1, 32'(unf_o[1]), 1);
        chk("unf_sp",   1, 32'(sp_o[1]),  31);
        dbg(3, '0);
        idle();
        for (int w = 0; w < 2; w++) begin
            chk("clr_unf", w, 32'(unf_o[w]), 0);
            chk("clr_ovf", w, 32'(ovf_o[w]), 0);
            chk("clr_irq", w, 32'(irq_o[w]), 0);
        end

        // Debug push collides with an op push: only the debug data lands.
        step(1, 0, 1, 8'h11, '0, 1, 2, 8'hA5);
        idle();
        chk("collide_sp",  0, 32'(sp_o[0]),  2);
        chk("collide_top", 0, 32'(top_o[0]), 32'hA5);
        chk("collide_sp",  1, 32'(sp_o[1]),  0);
        chk("collide_top", 1, 32'(top_o[1]), 32'hA5);

        // Peak occupancy: push to 7, pop to 2, then clear.
        dbg(3, '0);
        dbg(0, 8'd0);
        for (int i = 0; i < 7; i++) op(0, 1, 8'(i + 1), '0);
        op(2, 0, '0, '0);
        op(2, 0, '0, '0);
        op(1, 0, '0, '0);
        idle();
        for (int w = 0; w < 2; w++) begin
            chk("hwm_sp", w, 32'(sp_o[w]), 2);
`ifdef SPELL_STACK_HWM_EN
            chk("hwm_peak", w, 32'(maxd_o[w]), 7);
`else
            chk("hwm_peak", w, 32'(maxd_o[w]), 0);
`endif
        end
        dbg(3, '0);
        idle();
        for (int w = 0; w < 2; w++) chk("hwm_clear", w, 32'(maxd_o[w]), 0);

        // Randomised traffic, including host writes and flag clears.
        for (int n = 0; n < 4000; n++) begin
            bit              v;
            bit              d;
            int              a;
            logic [WIDTH-1:0] data;
            v = ($urandom_range(0, 9) < 8);
            d = ($urandom_range(0, 99) < 15);
            a = $urandom_range(0, 3);
            data = (d && a == 0) ? 8'($urandom_range(0, 63)) : 8'($urandom);
            step(v, $urandom_range(0, 3), $urandom_range(0, 3),
                 8'($urandom), 8'($urandom), d, a, data);
        end

        idle();
        idle();
        idle();
        #10;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
